// File: rtl/spawn_pos_sel_pkg.sv
// Shared breakout definitions: coordinate widths, play-area bounds and spawn FSM states.
package spawn_pos_sel_pkg;

  localparam int X_W = 11;
  localparam int Y_W = 10;

  localparam logic [X_W-1:0] X_MIN_DEF = 11'd16;
  localparam logic [X_W-1:0] X_MAX_DEF = 11'd623;
  localparam logic [Y_W-1:0] Y_MIN_DEF = 10'd240;
  localparam logic [Y_W-1:0] Y_MAX_DEF = 10'd400;
  localparam int             MAX_TRIES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    HOLD
  } state_t;

endpackage

// File: rtl/spawn_pos_sel_pos_clamp.sv
// Combinational play-area range check and per-axis clamp of a raw LFSR coordinate.
// With SPAWN_ALIGN_EN defined, the resulting x is snapped down to the 8-pixel brick grid.
module pos_clamp
  import spawn_pos_sel_pkg::*;
#(
  parameter logic [X_W-1:0] X_MIN = X_MIN_DEF,
  parameter logic [X_W-1:0] X_MAX = X_MAX_DEF,
  parameter logic [Y_W-1:0] Y_MIN = Y_MIN_DEF,
  parameter logic [Y_W-1:0] Y_MAX = Y_MAX_DEF
) (
  input  logic [X_W-1:0] x_in,
  input  logic [Y_W-1:0] y_in,
  output logic           in_range,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out
);

  logic           x_lo, x_hi, y_lo, y_hi;
  logic [X_W-1:0] x_clamped;

  assign x_lo = (x_in < X_MIN);
  assign x_hi = (x_in > X_MAX);
  assign y_lo = (y_in < Y_MIN);
  assign y_hi = (y_in > Y_MAX);

  assign in_range  = !(x_lo || x_hi || y_lo || y_hi);
  assign x_clamped = x_lo ? X_MIN : (x_hi ? X_MAX : x_in);
  assign y_out     = y_lo ? Y_MIN : (y_hi ? Y_MAX : y_in);

`ifdef SPAWN_ALIGN_EN
  // X_MIN is grid-aligned, so rounding down never leaves the play area.
  assign x_out = {x_clamped[X_W-1:3], 3'b000};
`else
  assign x_out = x_clamped;
`endif

endmodule

// File: rtl/spawn_pos_sel.sv
// Ball spawn position selector: bounded rejection sampling of the LFSR, clamp fallback,
// valid/ready output. Optional macro SPAWN_ALIGN_EN aligns spawn_x to the 8-pixel grid.
module spawn_pos_sel
  import spawn_pos_sel_pkg::*;
#(
  parameter logic [X_W-1:0] X_MIN     = X_MIN_DEF,
  parameter logic [X_W-1:0] X_MAX     = X_MAX_DEF,
  parameter logic [Y_W-1:0] Y_MIN     = Y_MIN_DEF,
  parameter logic [Y_W-1:0] Y_MAX     = Y_MAX_DEF,
  parameter int             MAX_TRIES = MAX_TRIES_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [X_W-1:0] x_loc,
  input  logic [Y_W-1:0] y_loc,
  input  logic           req,
  output logic [X_W-1:0] spawn_x,
  output logic [Y_W-1:0] spawn_y,
  output logic           spawn_valid,
  input  logic           spawn_ready,
  output logic [7:0]     fallback_cnt
);

  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  state_t           state_q, state_d;
  logic [TRY_W-1:0] try_q, try_d;
  logic [X_W-1:0]   x_d;
  logic [Y_W-1:0]   y_d;
  logic             valid_d;
  logic [7:0]       fb_d;

  logic             in_range;
  logic [X_W-1:0]   sel_x;
  logic [Y_W-1:0]   sel_y;

  pos_clamp #(
    .X_MIN(X_MIN),
    .X_MAX(X_MAX),
    .Y_MIN(Y_MIN),
    .Y_MAX(Y_MAX)
  ) u_clamp (
    .x_in    (x_loc),
    .y_in    (y_loc),
    .in_range(in_range),
    .x_out   (sel_x),
    .y_out   (sel_y)
  );

  // An in-range sample passes through the clamp unchanged, so both outcomes load sel_x/sel_y.
  always_comb begin
    state_d = state_q;
    try_d   = try_q;
    x_d     = spawn_x;
    y_d     = spawn_y;
    valid_d = spawn_valid;
    fb_d    = fallback_cnt;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (req) begin
          state_d = SAMPLE;
          try_d   = '0;
        end
      end
      SAMPLE: begin
        if (in_range || (try_q == LAST_TRY)) begin
          x_d     = sel_x;
          y_d     = sel_y;
          valid_d = 1'b1;
          state_d = HOLD;
          if (!in_range && (fallback_cnt != 8'hFF)) begin
            fb_d = fallback_cnt + 8'd1;
          end
        end else begin
          try_d = try_q + 1'b1;
        end
      end
      HOLD: begin
        if (spawn_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      try_q        <= '0;
      spawn_x      <= '0;
      spawn_y      <= '0;
      spawn_valid  <= 1'b0;
      fallback_cnt <= 8'd0;
    end else begin
      state_q      <= state_d;
      try_q        <= try_d;
      spawn_x      <= x_d;
      spawn_y      <= y_d;
      spawn_valid  <= valid_d;
      fallback_cnt <= fb_d;
    end
  end

`ifdef SPAWN_ALIGN_EN
  always @(posedge clk) begin
    assert (X_MIN[2:0] == 3'd0);
  end
`endif

endmodule

// File: tb/tb_spawn_pos_sel.sv
// Directed self-checking bench for spawn_pos_sel (honours SPAWN_ALIGN_EN when defined).
module tb_spawn_pos_sel;

  logic        clk;
  logic        rst_n;
  logic [10:0] x_loc;
  logic [9:0]  y_loc;
  logic        req;
  logic [10:0] spawn_x;
  logic [9:0]  spawn_y;
  logic        spawn_valid;
  logic        spawn_ready;
  logic [7:0]  fallback_cnt;

  int compared;
  int mismatched;
  int fb_exp;

  spawn_pos_sel dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .x_loc       (x_loc),
    .y_loc       (y_loc),
    .req         (req),
    .spawn_x     (spawn_x),
    .spawn_y     (spawn_y),
    .spawn_valid (spawn_valid),
    .spawn_ready (spawn_ready),
    .fallback_cnt(fallback_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] alignedX(input logic [10:0] x);
`ifdef SPAWN_ALIGN_EN
    return {x[10:3], 3'b000};
`else
    return x;
`endif
  endfunction

  // Drive inputs, let one active edge consume them, then settle 1 time unit past the edge.
  task automatic applyStimulus(input logic r, input logic [10:0] x, input logic [9:0] y,
                               input logic rdy);
    req         = r;
    x_loc       = x;
    y_loc       = y;
    spawn_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic v, input logic [10:0] x,
                          input logic [9:0] y);
    checkOutput({tag, ".valid"}, {31'd0, spawn_valid}, {31'd0, v});
    checkOutput({tag, ".x"}, {21'd0, spawn_x}, {21'd0, x});
    checkOutput({tag, ".y"}, {22'd0, spawn_y}, {22'd0, y});
    checkOutput({tag, ".fb"}, {24'd0, fallback_cnt}, fb_exp);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    fb_exp     = 0;
    rst_n = 1'b0;
    req = 1'b0; x_loc = '0; y_loc = '0; spawn_ready = 1'b0;

    applyStimulus(1'b1, 11'd100, 10'd300, 1'b0);
    checkAll("reset", 1'b0, 11'd0, 10'd0);
    rst_n = 1'b1;

    // In-range first sample
    applyStimulus(1'b1, 11'd100, 10'd300, 1'b0);
    checkOutput("first.idle_to_sample", {31'd0, spawn_valid}, 32'd0);
    applyStimulus(1'b0, 11'd100, 10'd300, 1'b0);
    checkAll("first.hit", 1'b1, alignedX(11'd100), 10'd300);
    applyStimulus(1'b0, 11'd100, 10'd300, 1'b1);
    checkOutput("first.accept", {31'd0, spawn_valid}, 32'd0);

    // Rejection then hit
    applyStimulus(1'b1, 11'd700, 10'd300, 1'b0);
    applyStimulus(1'b0, 11'd700, 10'd300, 1'b0);
    checkOutput("rej.try0", {31'd0, spawn_valid}, 32'd0);
    applyStimulus(1'b0, 11'd5, 10'd300, 1'b0);
    checkOutput("rej.try1", {31'd0, spawn_valid}, 32'd0);
    applyStimulus(1'b0, 11'd200, 10'd250, 1'b0);
    checkAll("rej.hit", 1'b1, alignedX(11'd200), 10'd250);
    applyStimulus(1'b0, 11'd200, 10'd250, 1'b1);

    // Exact upper corner is in range
    applyStimulus(1'b1, 11'd623, 10'd400, 1'b0);
    applyStimulus(1'b0, 11'd623, 10'd400, 1'b0);
    checkAll("corner.hi", 1'b1, alignedX(11'd623), 10'd400);
    applyStimulus(1'b0, 11'd0, 10'd0, 1'b1);

    // Stuck out-of-range LFSR falls back to clamped values after four tries
    applyStimulus(1'b1, 11'd2000, 10'd10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 11'd2000, 10'd10, 1'b0);
      checkOutput("fb.pending", {31'd0, spawn_valid}, 32'd0);
    end
    applyStimulus(1'b0, 11'd2000, 10'd10, 1'b0);
    fb_exp = 1;
    checkAll("fb.clamp", 1'b1, alignedX(11'd623), 10'd240);
    applyStimulus(1'b0, 11'd0, 10'd0, 1'b1);

    // Low-side clamp
    applyStimulus(1'b1, 11'd3, 10'd1000, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 11'd3, 10'd1000, 1'b0);
    fb_exp = 2;
    checkAll("fb.clamp_lo", 1'b1, alignedX(11'd16), 10'd400);
    applyStimulus(1'b0, 11'd0, 10'd0, 1'b1);

    // Backpressure: result held while inputs and req wiggle
    applyStimulus(1'b1, 11'd100, 10'd300, 1'b0);
    applyStimulus(1'b0, 11'd100, 10'd300, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(i[0], 11'(i * 37), 10'(i * 41), 1'b0);
      checkAll("bp.hold", 1'b1, alignedX(11'd100), 10'd300);
    end
    // Accept with req still high: one idle bubble, then a fresh result
    applyStimulus(1'b1, 11'd300, 10'd350, 1'b1);
    checkOutput("bp.accept", {31'd0, spawn_valid}, 32'd0);
    applyStimulus(1'b1, 11'd300, 10'd350, 1'b0);
    checkOutput("bp.bubble", {31'd0, spawn_valid}, 32'd0);
    applyStimulus(1'b0, 11'd300, 10'd350, 1'b0);
    checkAll("bp.next", 1'b1, alignedX(11'd300), 10'd350);
    applyStimulus(1'b0, 11'd0, 10'd0, 1'b1);

    // Alignment sample
    applyStimulus(1'b1, 11'd103, 10'd300, 1'b0);
    applyStimulus(1'b0, 11'd103, 10'd300, 1'b0);
`ifdef SPAWN_ALIGN_EN
    checkAll("align", 1'b1, 11'd96, 10'd300);
`else
    checkAll("align", 1'b1, 11'd103, 10'd300);
`endif
    applyStimulus(1'b0, 11'd0, 10'd0, 1'b1);

    // Saturation of fallback counter
    for (int n = 0; n < 256; n++) begin
      applyStimulus(1'b1, 11'd2047, 10'd0, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 11'd2047, 10'd0, 1'b0);
      if (fb_exp < 255) fb_exp++;
      applyStimulus(1'b0, 11'd0, 10'd0, 1'b1);
    end
    checkOutput("fb.saturate", {24'd0, fallback_cnt}, 32'd255);

    // Asynchronous reset mid-HOLD
    applyStimulus(1'b1, 11'd100, 10'd300, 1'b0);
    applyStimulus(1'b0, 11'd100, 10'd300, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    fb_exp = 0;
    checkAll("rst.hold", 1'b0, 11'd0, 10'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Asynchronous reset mid-SAMPLE
    applyStimulus(1'b1, 11'd2000, 10'd10, 1'b0);
    applyStimulus(1'b0, 11'd2000, 10'd10, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkAll("rst.sample", 1'b0, 11'd0, 10'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Normal service after reset
    applyStimulus(1'b1, 11'd100, 10'd300, 1'b0);
    checkOutput("post.sample", {31'd0, spawn_valid}, 32'd0);
    applyStimulus(1'b0, 11'd100, 10'd300, 1'b0);
    checkAll("post.hit", 1'b1, alignedX(11'd100), 10'd300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
